// File: rtl/kamacore_issue_stage.sv
// RV32I decode/issue stage: one-entry decode buffer, busy-bit scoreboard for RAW/WAW
// hazards, and a valid/ready execute register fed from the register file read ports.
module kamacore_issue_stage #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  output logic [REG_ADDR_WIDTH-1:0] rs1_a,
  input  logic [CPU_WIDTH-1:0]      rs1_data,
  output logic [REG_ADDR_WIDTH-1:0] rs2_a,
  input  logic [CPU_WIDTH-1:0]      rs2_data,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_a,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [6:0]                ex_opcode,
  output logic [3:0]                ex_funct,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_a,
  output logic                      ex_rd_we,
  output logic [CPU_WIDTH-1:0]      ex_rs1_data,
  output logic [CPU_WIDTH-1:0]      ex_rs2_data,
  output logic [CPU_WIDTH-1:0]      ex_imm,
  output logic                      ex_illegal
);

  localparam int NREG = 2 ** REG_ADDR_WIDTH;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic                      d_valid_q, d_valid_d;
  logic [31:0]               d_instr_q, d_instr_d;
  logic [NREG-1:0]           busy_q, busy_d;

  logic                      ex_valid_q, ex_valid_d;
  logic [6:0]                ex_opcode_q;
  logic [3:0]                ex_funct_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_a_q;
  logic                      ex_rd_we_q;
  logic [CPU_WIDTH-1:0]      ex_rs1_data_q, ex_rs2_data_q;
  logic signed [CPU_WIDTH-1:0] ex_imm_q;
  logic                      ex_illegal_q;

  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic                      uses_rs1, uses_rs2, uses_rd, writes_rd, illegal;
  logic signed [CPU_WIDTH-1:0] imm;
  logic                      hazard, issue;

  assign opcode    = d_instr_q[6:0];
  assign rd        = d_instr_q[11:7];
  assign rs1       = d_instr_q[19:15];
  assign rs2       = d_instr_q[24:20];
  assign rs1_a     = rs1;
  assign rs2_a     = rs2;
  assign writes_rd = uses_rd & (rd != '0);

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    uses_rd  = 1'b0;
    illegal  = 1'b0;
    imm      = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        uses_rd = 1'b1;
        imm     = {d_instr_q[31:12], 12'b0};
      end
      OPC_JAL: begin
        uses_rd = 1'b1;
        imm     = {{11{d_instr_q[31]}}, d_instr_q[31], d_instr_q[19:12],
                   d_instr_q[20], d_instr_q[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        imm      = {{20{d_instr_q[31]}}, d_instr_q[31:20]};
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{19{d_instr_q[31]}}, d_instr_q[31], d_instr_q[7],
                    d_instr_q[30:25], d_instr_q[11:8], 1'b0};
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{20{d_instr_q[31]}}, d_instr_q[31:25], d_instr_q[11:7]};
      end
      OPC_OP: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // A writeback landing this cycle resolves the hazard; the register file bypasses the value.
  always_comb begin
    hazard = (uses_rs1  & busy_q[rs1] & !(wb_we & (wb_a == rs1)))
           | (uses_rs2  & busy_q[rs2] & !(wb_we & (wb_a == rs2)))
           | (writes_rd & busy_q[rd]  & !(wb_we & (wb_a == rd)));
    issue    = d_valid_q & !hazard & (!ex_valid_q | ex_ready) & !flush;
    in_ready = !d_valid_q | issue;
  end

  always_comb begin
    d_valid_d = d_valid_q;
    d_instr_d = d_instr_q;
    if (flush) begin
      d_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      d_valid_d = 1'b1;
      d_instr_d = in_instr;
    end else if (issue) begin
      d_valid_d = 1'b0;
    end

    ex_valid_d = ex_valid_q;
    if (flush)         ex_valid_d = 1'b0;
    else if (issue)    ex_valid_d = 1'b1;
    else if (ex_ready) ex_valid_d = 1'b0;

    // Set after clear so a reissued destination stays busy; a flushed write never arrives.
    busy_d = busy_q;
    if (wb_we) busy_d[wb_a] = 1'b0;
    if (flush && ex_valid_q && ex_rd_we_q) busy_d[ex_rd_a_q] = 1'b0;
    if (issue && writes_rd) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid_q     <= 1'b0;
      d_instr_q     <= '0;
      busy_q        <= '0;
      ex_valid_q    <= 1'b0;
      ex_opcode_q   <= '0;
      ex_funct_q    <= '0;
      ex_rd_a_q     <= '0;
      ex_rd_we_q    <= 1'b0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_illegal_q  <= 1'b0;
    end else begin
      d_valid_q  <= d_valid_d;
      d_instr_q  <= d_instr_d;
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      if (issue) begin
        ex_opcode_q   <= opcode;
        ex_funct_q    <= {d_instr_q[30], d_instr_q[14:12]};
        ex_rd_a_q     <= rd;
        ex_rd_we_q    <= writes_rd;
        ex_rs1_data_q <= uses_rs1 ? rs1_data : '0;
        ex_rs2_data_q <= uses_rs2 ? rs2_data : '0;
        ex_imm_q      <= imm;
        ex_illegal_q  <= illegal;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_funct    = ex_funct_q;
  assign ex_rd_a     = ex_rd_a_q;
  assign ex_rd_we    = ex_rd_we_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_illegal  = ex_illegal_q;

endmodule
